resp_tx: RTL

Response transmitter for the GPU host link. It is the outbound counterpart of the memory controller's UART command receiver. It queues 16-bit answer words from the memory controller (e.g. 0xAAAA init ack, 0xFFFF end-of-frame ack) in a small FIFO. Each word is serialized MSB-byte-first to the UART transmitter, one byte at a time, using the start/sent handshake. A no-answer timeout keeps the link from hanging if the UART never reports completion.

---
 rtl/resp_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/resp_tx.sv
// Response transmitter for the GPU host link.
// Buffers 16-bit answer words from the memory controller in a small FIFO and
// serializes each one MSB byte first to the UART transmitter using the
// start/sent handshake. A per-byte no-answer timeout keeps the link moving if
// the UART never reports completion.
module resp_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [15:0]                   iRespWord,
    input  logic                          iRespValid,
    output logic                          oRespReady,
    output logic [7:0]                    oTxByte,
    output logic                          oTxStart,
    input  logic                          iTxSent,
    output logic                          oBusy,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel,
    output logic                          oOverflow,
    output logic                          oTimeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    // Last timer value before a byte is declared lost; unused when disabled.
    localparam int unsigned   TIMER_LAST_I = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMER_LAST_I);
    localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam bit            TIMEOUT_EN   = (TIMEOUT != 0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEND_HI = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] SEND_LO = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;

    logic [15:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic [15:0]   headWord;

    logic [2:0]    state;
    logic [2:0]    stateNext;
    logic [15:0]   word;
    logic [TW-1:0] timer;
    logic [7:0]    txByte;
    logic          txStart;
    logic          overflow;

    logic          pushEn;
    logic          popEn;
    logic          isFull;
    logic          loadHi;
    logic          loadLo;
    logic          timerClear;
    logic          timerInc;
    logic          timeoutHit;

    assign headWord = fifoMem[rdPtr];

    // FIFO handshake decode; a full FIFO rejects a push even when popping.
    always_comb begin
        isFull = (count == FULL_COUNT);
        if (iRespValid && !isFull) begin
            pushEn = 1'b1;
        end else begin
            pushEn = 1'b0;
        end
        if ((state == IDLE) && (count != '0)) begin
            popEn = 1'b1;
        end else begin
            popEn = 1'b0;
        end
    end

    // Next-state logic: byte sequencing, handshake and timeout decisions.
    always_comb begin
        stateNext  = state;
        loadHi     = 1'b0;
        loadLo     = 1'b0;
        timerClear = 1'b0;
        timerInc   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    stateNext = SEND_HI;
                    loadHi    = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            SEND_HI: begin
                stateNext  = WAIT_HI;
                timerClear = 1'b1;
            end
            WAIT_HI: begin
                if (iTxSent) begin
                    stateNext = SEND_LO;
                    loadLo    = 1'b1;
                end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end else begin
                    timerInc = 1'b1;
                end
            end
            SEND_LO: begin
                stateNext  = WAIT_LO;
                timerClear = 1'b1;
            end
            WAIT_LO: begin
                if (iTxSent) begin
                    stateNext = IDLE;
                end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end else begin
                    timerInc = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because pointers gate every read.
    always_ff @(posedge iClock) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= iRespWord;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FSM state, word latch and per-byte timer (saturating when disabled).
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
            word  <= 16'h0000;
            timer <= '0;
        end else begin
            state <= stateNext;
            if (loadHi) begin
                word <= headWord;
            end
            if (timerClear) begin
                timer <= '0;
            end else if (timerInc && (timer != TIMER_MAX)) begin
                timer <= timer + TIMER_ONE;
            end
        end
    end

    // Registered UART strobe and byte: valid together during the SEND cycle,
    // byte held until the next SEND.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            txByte  <= 8'h00;
            txStart <= 1'b0;
        end else if (loadHi) begin
            txByte  <= headWord[15:8];
            txStart <= 1'b1;
        end else if (loadLo) begin
            txByte  <= word[7:0];
            txStart <= 1'b1;
        end else begin
            txStart <= 1'b0;
        end
    end

    // Registered overflow pulse for a push refused because the FIFO is full.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= iRespValid && isFull;
        end
    end

    assign oTxByte    = txByte;
    assign oTxStart   = txStart;
    assign oOverflow  = overflow;
    assign oRespReady = !isFull;
    assign oLevel     = count;
    assign oBusy      = (state != IDLE) || (count != '0);
    // Flags the byte's final waiting cycle, exactly TIMEOUT cycles after its start.
    assign oTimeout   = timeoutHit;

endmodule
